muldiv_iter: RTL and testbench

MULDIV_ITER -- requirements
Module: muldiv_iter

---
 rtl/muldiv_pkg.sv | 57 +++++
 rtl/muldiv_iter.sv | 193 +++++++++++++++++++
 tb/tb_muldiv_iter.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg
// Shared definitions for the iterative RV32M multiply/divide unit:
// funct3 op codes, FSM state encoding, iteration count and small
// op-classification helpers used when an operation is accepted.
package muldiv_pkg;

    localparam int ITER_COUNT = 32;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    // funct3[2] separates the divide class from the multiply class
    function automatic logic is_div(input logic [2:0] f);
        return f[2];
    endfunction

    // funct3[1] selects remainder over quotient within the divide class
    function automatic logic is_rem(input logic [2:0] f);
        return f[2] & f[1];
    endfunction

    function automatic logic a_is_signed(input logic [2:0] f);
        return (f == OP_MUL) || (f == OP_MULH) || (f == OP_MULHSU) ||
               (f == OP_DIV) || (f == OP_REM);
    endfunction

    function automatic logic b_is_signed(input logic [2:0] f);
        return (f == OP_MUL) || (f == OP_MULH) ||
               (f == OP_DIV) || (f == OP_REM);
    endfunction

    // Sign of the final result; a remainder takes the dividend's sign only
    function automatic logic result_neg(input logic [2:0] f,
                                        input logic       a_msb,
                                        input logic       b_msb);
        logic sa;
        logic sb;
        sa = a_is_signed(f) & a_msb;
        sb = b_is_signed(f) & b_msb & ~is_rem(f);
        return sa ^ sb;
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// muldiv_iter
// Iterative RV32M multiply/divide unit. Multiplies by radix-2 shift-add
// and divides by restoring division, one bit per cycle over 32 cycles,
// on operand magnitudes; the sign is reapplied when the result is stored.
//
// Ports
//   clk     rising-edge clock
//   rst     asynchronous reset, active high
//   start   one-cycle request, accepted in IDLE or DONE
//   funct3  RV32M operation select
//   a, b    rs1 / rs2 operands, sampled with start
//   busy    high while iterating (registered)
//   done    one-cycle pulse, result valid (registered)
//   result  registered result, held until the next done
//
// state   | meaning
// ST_IDLE | waiting for start
// ST_RUN  | iterating, one bit per cycle
// ST_DONE | result valid, done asserted for one cycle
module muldiv_iter
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int W2 = 2 * WIDTH;

    state_e             state_q, state_d;
    op_e                op_q, op_d;
    logic               neg_q, neg_d;
    logic [5:0]         cnt_q, cnt_d;
    // MUL: running product. DIV: {remainder, dividend/quotient}.
    logic [W2-1:0]      acc_q, acc_d;
    // MUL: multiplicand shifted left each step. DIV: divisor in low half.
    logic [W2-1:0]      opb_q, opb_d;
    // MUL: multiplier shifted right each step.
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               accept;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;

    logic [WIDTH:0]     trial;
    logic [W2-1:0]      step_acc;
    logic [W2-1:0]      step_opb;
    logic [WIDTH-1:0]   step_mplier;
    logic [W2-1:0]      prod_signed;
    logic [WIDTH-1:0]   div_sel;
    logic [WIDTH-1:0]   final_res;

    assign accept = start && (state_q != ST_RUN);

    // Magnitudes of the incoming operands; 0x80000000 maps to 2^31 unsigned
    always_comb begin
        mag_a = a;
        mag_b = b;
        if (a_is_signed(funct3) && a[WIDTH-1]) begin
            mag_a = ~a + 1'b1;
        end
        if (b_is_signed(funct3) && b[WIDTH-1]) begin
            mag_b = ~b + 1'b1;
        end
    end

    // One iteration of the datapath plus the signed result it would yield
    always_comb begin
        trial       = acc_q[W2-1:WIDTH-1] - {1'b0, opb_q[WIDTH-1:0]};
        step_acc    = acc_q;
        step_opb    = opb_q;
        step_mplier = mplier_q;
        if (is_div(op_q)) begin
            // Restore (keep the shifted remainder) when the trial subtract borrows
            if (trial[WIDTH]) begin
                step_acc = {acc_q[W2-2:0], 1'b0};
            end else begin
                step_acc = {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
            end
        end else begin
            if (mplier_q[0]) begin
                step_acc = acc_q + opb_q;
            end
            step_opb    = opb_q << 1;
            step_mplier = mplier_q >> 1;
        end

        prod_signed = neg_q ? (~step_acc + 1'b1) : step_acc;
        div_sel     = is_rem(op_q) ? step_acc[W2-1:WIDTH] : step_acc[WIDTH-1:0];

        if (is_div(op_q)) begin
            final_res = neg_q ? (~div_sel + 1'b1) : div_sel;
        end else if (op_q == OP_MUL) begin
            final_res = prod_signed[WIDTH-1:0];
        end else begin
            final_res = prod_signed[W2-1:WIDTH];
        end
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        neg_d    = neg_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opb_d    = opb_q;
        mplier_d = mplier_q;
        result_d = result_q;

        if (accept) begin
            op_d  = op_e'(funct3);
            neg_d = result_neg(funct3, a[WIDTH-1], b[WIDTH-1]);
            cnt_d = '0;
            if (is_div(funct3)) begin
                acc_d    = {{WIDTH{1'b0}}, mag_a};
                opb_d    = {{WIDTH{1'b0}}, mag_b};
                mplier_d = '0;
                if (b == '0) begin
                    // Divide by zero bypasses iteration entirely
                    state_d  = ST_DONE;
                    result_d = is_rem(funct3) ? a : '1;
                end else begin
                    state_d = ST_RUN;
                end
            end else begin
                acc_d    = '0;
                opb_d    = {{WIDTH{1'b0}}, mag_a};
                mplier_d = mag_b;
                state_d  = ST_RUN;
            end
        end else begin
            case (state_q)
                ST_RUN: begin
                    acc_d    = step_acc;
                    opb_d    = step_opb;
                    mplier_d = step_mplier;
                    cnt_d    = cnt_q + 6'd1;
                    if (cnt_q == 6'(ITER_COUNT - 1)) begin
                        state_d  = ST_DONE;
                        result_d = final_res;
                    end
                end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end

        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_MUL;
            neg_q    <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
            opb_q    <= '0;
            mplier_q <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opb_q    <= opb_d;
            mplier_q <= mplier_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_muldiv_iter.sv
// tb_muldiv_iter
// Self-checking bench for muldiv_iter: directed corner cases plus random
// operations checked against a 64-bit arithmetic reference model.
// Inputs are driven and outputs sampled 1 ns after each rising edge.
// Latency is counted in edges after the accepting edge E0: a normal op
// shows done after E32 (lat 32, busy seen for 32 samples), divide by zero
// shows done right after E0 (lat 0).
module tb_muldiv_iter;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int tests_run    = 0;
    int tests_failed = 0;

    muldiv_iter #(.WIDTH(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .funct3 (funct3),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    // RV32M semantics from plain 64-bit arithmetic
    function automatic logic [31:0] ref_muldiv(input logic [2:0] f,
                                               input logic [31:0] x,
                                               input logic [31:0] y);
        longint sx;
        longint sy;
        longint ux;
        longint uy;
        longint p;
        sx = {{32{x[31]}}, x};
        sy = {{32{y[31]}}, y};
        ux = {32'b0, x};
        uy = {32'b0, y};
        case (f)
            3'd0: begin p = sx * sy; return p[31:0];  end
            3'd1: begin p = sx * sy; return p[63:32]; end
            3'd2: begin p = sx * uy; return p[63:32]; end
            3'd3: begin p = ux * uy; return p[63:32]; end
            3'd4: begin
                if (y == 0) return 32'hFFFF_FFFF;
                p = sx / sy; return p[31:0];
            end
            3'd5: begin
                if (y == 0) return 32'hFFFF_FFFF;
                p = ux / uy; return p[31:0];
            end
            3'd6: begin
                if (y == 0) return x;
                p = sx % sy; return p[31:0];
            end
            default: begin
                if (y == 0) return x;
                p = ux % uy; return p[31:0];
            end
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] f, input logic [31:0] y);
        return (f[2] && y == 0) ? 0 : 32;
    endfunction

    // Issue one op (caller is 1 ns after an edge) and wait for done.
    // Operands are scrambled after acceptance so they must not matter.
    task automatic do_op(input  logic [2:0]  f,
                         input  logic [31:0] ia,
                         input  logic [31:0] ib,
                         output logic [31:0] res,
                         output int          lat,
                         output int          busy_cnt);
        funct3 = f;
        a      = ia;
        b      = ib;
        start  = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        funct3   = 3'($urandom);
        a        = $urandom;
        b        = $urandom;
        lat      = 0;
        busy_cnt = 0;
        while (!done && lat < 100) begin
            if (busy) busy_cnt++;
            @(posedge clk); #1;
            lat++;
        end
        if (busy) busy_cnt++;
        res = result;
    endtask

    task automatic idle_cycle();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; funct3 = '0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b want 0", busy); end
        tests_run++;
        if (done !== 1'b0) begin tests_failed++; $display("FAIL reset_done: got %b want 0", done); end
        tests_run++;
        if (result !== 32'h0) begin tests_failed++; $display("FAIL reset_result: got %h want 00000000", result); end
        rst = 1'b0;
        idle_cycle();
        tests_run++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            tests_failed++; $display("FAIL reset_release: busy %b done %b want 0 0", busy, done);
        end
    endtask

    task automatic test_mul();
        logic [31:0] r;
        int lat, bc;
        do_op(3'b000, 32'd7, 32'hFFFF_FFFD, r, lat, bc);
        tests_run++;
        if (r !== 32'hFFFF_FFEB) begin tests_failed++; $display("FAIL mul_neg: got %h want FFFFFFEB", r); end
        tests_run++;
        if (lat !== 32) begin tests_failed++; $display("FAIL mul_latency: got %0d want 32", lat); end
        tests_run++;
        if (bc !== 32) begin tests_failed++; $display("FAIL mul_busy_cycles: got %0d want 32", bc); end
        idle_cycle();
        tests_run++;
        if (done !== 1'b0) begin tests_failed++; $display("FAIL done_pulse_width: got %b want 0", done); end
        tests_run++;
        if (result !== 32'hFFFF_FFEB) begin tests_failed++; $display("FAIL result_hold: got %h want FFFFFFEB", result); end

        do_op(3'b001, 32'h8000_0000, 32'h8000_0000, r, lat, bc);
        tests_run++;
        if (r !== 32'h4000_0000) begin tests_failed++; $display("FAIL mulh_minmin: got %h want 40000000", r); end
        idle_cycle();
        do_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r, lat, bc);
        tests_run++;
        if (r !== 32'hFFFF_FFFE) begin tests_failed++; $display("FAIL mulhu_max: got %h want FFFFFFFE", r); end
        idle_cycle();
        do_op(3'b010, 32'hFFFF_FFFF, 32'h0000_0002, r, lat, bc);
        tests_run++;
        if (r !== 32'hFFFF_FFFF) begin tests_failed++; $display("FAIL mulhsu_neg: got %h want FFFFFFFF", r); end
        idle_cycle();
    endtask

    task automatic test_div();
        logic [31:0] r;
        int lat, bc;
        do_op(3'b100, 32'hFFFF_FFF9, 32'd2, r, lat, bc);
        tests_run++;
        if (r !== 32'hFFFF_FFFD) begin tests_failed++; $display("FAIL div_neg: got %h want FFFFFFFD", r); end
        tests_run++;
        if (lat !== 32) begin tests_failed++; $display("FAIL div_latency: got %0d want 32", lat); end
        idle_cycle();
        do_op(3'b110, 32'hFFFF_FFF9, 32'd2, r, lat, bc);
        tests_run++;
        if (r !== 32'hFFFF_FFFF) begin tests_failed++; $display("FAIL rem_neg: got %h want FFFFFFFF", r); end
        idle_cycle();
    endtask

    task automatic test_div_special();
        logic [31:0] r;
        int lat, bc;
        do_op(3'b101, 32'd5, 32'd0, r, lat, bc);
        tests_run++;
        if (r !== 32'hFFFF_FFFF) begin tests_failed++; $display("FAIL divu_zero: got %h want FFFFFFFF", r); end
        tests_run++;
        if (lat !== 0) begin tests_failed++; $display("FAIL divzero_latency: got %0d want 0", lat); end
        tests_run++;
        if (bc !== 0) begin tests_failed++; $display("FAIL divzero_busy: got %0d want 0", bc); end
        idle_cycle();
        do_op(3'b111, 32'd5, 32'd0, r, lat, bc);
        tests_run++;
        if (r !== 32'd5) begin tests_failed++; $display("FAIL remu_zero: got %h want 00000005", r); end
        idle_cycle();
        do_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, r, lat, bc);
        tests_run++;
        if (r !== 32'h8000_0000) begin tests_failed++; $display("FAIL div_overflow: got %h want 80000000", r); end
        tests_run++;
        if (lat !== 32) begin tests_failed++; $display("FAIL overflow_latency: got %0d want 32", lat); end
        idle_cycle();
        do_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, r, lat, bc);
        tests_run++;
        if (r !== 32'h0) begin tests_failed++; $display("FAIL rem_overflow: got %h want 00000000", r); end
        idle_cycle();
    endtask

    task automatic test_reset_abort();
        logic [31:0] r;
        int lat, bc, done_seen;
        funct3 = 3'b000; a = 32'd3; b = 32'd4; start = 1'b1;
        idle_cycle();
        start = 1'b0;
        repeat (9) idle_cycle();
        rst = 1'b1;
        #1;
        tests_run++;
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL abort_busy: got %b want 0", busy); end
        tests_run++;
        if (result !== 32'h0) begin tests_failed++; $display("FAIL abort_result: got %h want 00000000", result); end
        @(posedge clk); #1;
        rst = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) done_seen++;
            idle_cycle();
        end
        tests_run++;
        if (done_seen !== 0) begin tests_failed++; $display("FAIL abort_no_done: got %0d pulses want 0", done_seen); end
        do_op(3'b101, 32'd100, 32'd7, r, lat, bc);
        tests_run++;
        if (r !== 32'd14) begin tests_failed++; $display("FAIL post_abort_divu: got %h want 0000000e", r); end
        tests_run++;
        if (lat !== 32) begin tests_failed++; $display("FAIL post_abort_latency: got %0d want 32", lat); end
        idle_cycle();
    endtask

    task automatic test_ignore_start();
        logic [31:0] exp;
        int lat;
        exp = ref_muldiv(3'b011, 32'hDEAD_BEEF, 32'h1234_5678);
        funct3 = 3'b011; a = 32'hDEAD_BEEF; b = 32'h1234_5678; start = 1'b1;
        idle_cycle();
        start = 1'b0;
        repeat (4) idle_cycle();
        // A divide by zero here would finish at once if wrongly accepted
        funct3 = 3'b100; a = 32'd100; b = 32'd0; start = 1'b1;
        idle_cycle();
        start = 1'b0;
        lat = 5;
        while (!done && lat < 100) begin
            idle_cycle();
            lat++;
        end
        tests_run++;
        if (result !== exp) begin tests_failed++; $display("FAIL ignore_start_result: got %h want %h", result, exp); end
        tests_run++;
        if (lat !== 32) begin tests_failed++; $display("FAIL ignore_start_latency: got %0d want 32", lat); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] r;
        int lat, bc;
        // Caller leaves us in the done cycle of the previous op
        do_op(3'b110, 32'd1000, 32'hFFFF_FFF9, r, lat, bc);
        tests_run++;
        if (r !== ref_muldiv(3'b110, 32'd1000, 32'hFFFF_FFF9)) begin
            tests_failed++; $display("FAIL b2b_first: got %h want %h", r, ref_muldiv(3'b110, 32'd1000, 32'hFFFF_FFF9));
        end
        do_op(3'b001, 32'h1234_5678, 32'h8765_4321, r, lat, bc);
        tests_run++;
        if (r !== ref_muldiv(3'b001, 32'h1234_5678, 32'h8765_4321)) begin
            tests_failed++; $display("FAIL b2b_second: got %h want %h", r, ref_muldiv(3'b001, 32'h1234_5678, 32'h8765_4321));
        end
        tests_run++;
        if (lat !== 32) begin tests_failed++; $display("FAIL b2b_latency: got %0d want 32", lat); end
        idle_cycle();
    endtask

    task automatic test_random();
        logic [31:0] r, ra, rb, exp;
        logic [2:0]  rf;
        int lat, bc, kind;
        for (int n = 0; n < 40; n++) begin
            rf   = 3'($urandom_range(0, 7));
            ra   = $urandom;
            kind = $urandom_range(0, 9);
            if (kind == 0) begin
                rb = 32'h0;
            end else if (kind == 1) begin
                ra = 32'h8000_0000; rb = 32'hFFFF_FFFF;
            end else if (kind == 2) begin
                rb = 32'($urandom_range(1, 15));
            end else begin
                rb = $urandom;
            end
            exp = ref_muldiv(rf, ra, rb);
            do_op(rf, ra, rb, r, lat, bc);
            tests_run++;
            if (r !== exp || lat !== ref_latency(rf, rb)) begin
                tests_failed++;
                $display("FAIL random_op f3=%0d a=%h b=%h: got %h lat %0d want %h lat %0d",
                         rf, ra, rb, r, lat, exp, ref_latency(rf, rb));
            end
            if ($urandom_range(0, 1) == 1) idle_cycle();
        end
        idle_cycle();
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_div_special();
        test_reset_abort();
        test_ignore_start();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
